// File: rtl/ir_nec_pkg.sv
// Shared NEC/HT6221 IR definitions: FSM states, default timing (50 MHz cycles)
// common to the transmit and receive paths, and phase counter width.
package ir_nec_pkg;

    localparam int unsigned PHASE_W = 20;

    localparam int unsigned DEF_LEAD_MARK_CNT  = 450000;
    localparam int unsigned DEF_LEAD_SPACE_CNT = 225000;
    localparam int unsigned DEF_BIT_MARK_CNT   = 28000;
    localparam int unsigned DEF_ZERO_SPACE_CNT = 28000;
    localparam int unsigned DEF_ONE_SPACE_CNT  = 84500;
    localparam int unsigned DEF_GAP_CNT        = 1000000;
    localparam int unsigned DEF_CARRIER_DIV    = 1316;
    localparam int unsigned DEF_CARRIER_HIGH   = 438;

    typedef enum logic [2:0] {
        StIdle,
        StLeadMark,
        StLeadSpace,
        StBitMark,
        StBitSpace,
        StStopMark,
        StGap
    } state_t;

    // Terminal phase-counter value for a phase lasting cnt cycles.
    function automatic logic [PHASE_W-1:0] phase_last(input int unsigned cnt);
        return PHASE_W'(cnt - 1);
    endfunction

endpackage

// File: rtl/ir_encode_if.sv
// Request/status bundle between a frame source and the IR encoder.
interface ir_encode_if;

    logic        start;
    logic [15:0] tx_addr;
    logic [15:0] tx_data;
    logic        busy;
    logic        done;

    modport master (
        output start,
        output tx_addr,
        output tx_data,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  tx_addr,
        input  tx_data,
        output busy,
        output done
    );

endinterface

// File: rtl/ir_carrier_gen.sv
// IR carrier generator: registered carrier, gated by enable, whose period
// restarts at count 0 on every rising edge of enable.
module ir_carrier_gen #(
    parameter int unsigned CARRIER_DIV  = ir_nec_pkg::DEF_CARRIER_DIV,
    parameter int unsigned CARRIER_HIGH = ir_nec_pkg::DEF_CARRIER_HIGH
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    output logic carrier
);

    localparam int unsigned CW = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(CARRIER_DIV - 1);
    localparam logic [CW-1:0] HIGH_CNT = CW'(CARRIER_HIGH);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          en_q;
    logic          carrier_d;

    // Count for the coming cycle; an enable rising edge forces count 0.
    always_comb begin
        if (enable && !en_q) begin
            cnt_d = '0;
        end else if (cnt_q == DIV_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        carrier_d = enable && (cnt_d < HIGH_CNT);
    end

    // Carrier phase and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            en_q    <= 1'b0;
            carrier <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            en_q    <= enable;
            carrier <= carrier_d;
        end
    end

endmodule

// File: rtl/ir_encode.sv
// NEC/HT6221 IR frame transmitter: leader, 32 pulse-distance bits LSB first
// (address then data), stop burst and a guaranteed idle gap.
// Optional macro IR_CARRIER_EN: modulate the envelope with the IR carrier;
// when undefined oIR is the baseband envelope.
module ir_encode
    import ir_nec_pkg::*;
#(
    parameter int unsigned LEAD_MARK_CNT  = DEF_LEAD_MARK_CNT,
    parameter int unsigned LEAD_SPACE_CNT = DEF_LEAD_SPACE_CNT,
    parameter int unsigned BIT_MARK_CNT   = DEF_BIT_MARK_CNT,
    parameter int unsigned ZERO_SPACE_CNT = DEF_ZERO_SPACE_CNT,
    parameter int unsigned ONE_SPACE_CNT  = DEF_ONE_SPACE_CNT,
    parameter int unsigned GAP_CNT        = DEF_GAP_CNT,
    parameter int unsigned CARRIER_DIV    = DEF_CARRIER_DIV,
    parameter int unsigned CARRIER_HIGH   = DEF_CARRIER_HIGH
) (
    input  logic       clk,
    input  logic       reset_n,
    ir_encode_if.slave bus,
    output logic       oIR
);

    localparam logic [PHASE_W-1:0] LEAD_MARK_LAST  = phase_last(LEAD_MARK_CNT);
    localparam logic [PHASE_W-1:0] LEAD_SPACE_LAST = phase_last(LEAD_SPACE_CNT);
    localparam logic [PHASE_W-1:0] BIT_MARK_LAST   = phase_last(BIT_MARK_CNT);
    localparam logic [PHASE_W-1:0] ZERO_SPACE_LAST = phase_last(ZERO_SPACE_CNT);
    localparam logic [PHASE_W-1:0] ONE_SPACE_LAST  = phase_last(ONE_SPACE_CNT);
    localparam logic [PHASE_W-1:0] GAP_LAST        = phase_last(GAP_CNT);

    // A carrier that is never high, or never low, is a configuration error.
    if (CARRIER_HIGH == 0 || CARRIER_HIGH >= CARRIER_DIV) begin : g_bad_carrier
        $error("ir_encode: CARRIER_HIGH must lie in 1..CARRIER_DIV-1");
    end

    state_t               state_q, state_d;
    logic [PHASE_W-1:0]   cnt_q, cnt_d;
    logic [4:0]           bit_q, bit_d;
    logic [31:0]          shift_q, shift_d;
    logic                 env_q, env_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 phase_end;

    // Detect the last cycle of the current phase; the space length follows the LSB.
    always_comb begin
        phase_end = 1'b0;
        case (state_q)
            StLeadMark:  phase_end = (cnt_q == LEAD_MARK_LAST);
            StLeadSpace: phase_end = (cnt_q == LEAD_SPACE_LAST);
            StBitMark:   phase_end = (cnt_q == BIT_MARK_LAST);
            StBitSpace:  phase_end = (cnt_q == (shift_q[0] ? ONE_SPACE_LAST : ZERO_SPACE_LAST));
            StStopMark:  phase_end = (cnt_q == BIT_MARK_LAST);
            StGap:       phase_end = (cnt_q == GAP_LAST);
            default:     phase_end = 1'b0;
        endcase
    end

    // Next-state, phase counter, bit counter and shift register.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        if (state_q == StIdle) begin
            cnt_d = '0;
            if (bus.start) begin
                state_d = StLeadMark;
                shift_d = {bus.tx_data, bus.tx_addr};
            end
        end else if (phase_end) begin
            cnt_d = '0;
            case (state_q)
                StLeadMark:  state_d = StLeadSpace;
                StLeadSpace: state_d = StBitMark;
                StBitMark:   state_d = StBitSpace;
                StBitSpace: begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 1'b1;
                    state_d = (bit_q == 5'd31) ? StStopMark : StBitMark;
                end
                StStopMark:  state_d = StGap;
                default:     state_d = StIdle;
            endcase
        end
    end

    // Outputs are registered from the next state so they align with it;
    // done lands on the last gap cycle, where busy already reads 0.
    always_comb begin
        env_d  = (state_d == StLeadMark) || (state_d == StBitMark) || (state_d == StStopMark);
        done_d = (state_d == StGap) && (cnt_d == GAP_LAST);
        busy_d = (state_d != StIdle) && !done_d;
    end

    // State and output registers; reset aborts any frame in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            env_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            env_q   <= env_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;

`ifdef IR_CARRIER_EN
    logic carrier;

    ir_carrier_gen #(
        .CARRIER_DIV  (CARRIER_DIV),
        .CARRIER_HIGH (CARRIER_HIGH)
    ) u_carrier (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (env_d),
        .carrier (carrier)
    );

    assign oIR = env_q & carrier;
`else
    assign oIR = env_q;
`endif

endmodule

// File: tb/tb_ir_encode.sv
// Bench for ir_encode with shortened timing: table of frames checked against
// hand-computed lengths and a cycle-level envelope model, plus sequences for
// ignored starts, mid-frame reset and back-to-back frames with start held.
module tb_ir_encode;

    localparam int unsigned LM   = 20;
    localparam int unsigned LS   = 10;
    localparam int unsigned BM   = 4;
    localparam int unsigned ZS   = 3;
    localparam int unsigned OS   = 7;
    localparam int unsigned GAP  = 15;
    localparam int unsigned DIV  = 5;
    localparam int unsigned HIGH = 2;
    localparam int LIMIT = 1000;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic oir;

    ir_encode_if bus ();

    ir_encode #(
        .LEAD_MARK_CNT  (LM),
        .LEAD_SPACE_CNT (LS),
        .BIT_MARK_CNT   (BM),
        .ZERO_SPACE_CNT (ZS),
        .ONE_SPACE_CNT  (OS),
        .GAP_CNT        (GAP),
        .CARRIER_DIV    (DIV),
        .CARRIER_HIGH   (HIGH)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .oIR     (oir)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        int          busy;
        int          sp0;
        int          sp8;
    } vec_t;

    vec_t vecs [5];
    int   errors = 0;
    int   checks = 0;
    bit   exp_q[$];
    bit   got_q[$];
    int   runs[$];
    int   cap_busy, cap_done, cap_falls;
    int   rises, dones;
    bit   bprev, fin;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic push_run(input bit v, input int n);
        for (int k = 0; k < n; k++) begin
`ifdef IR_CARRIER_EN
            exp_q.push_back(v && ((k % DIV) < HIGH));
`else
            exp_q.push_back(v);
`endif
        end
    endtask

    task automatic model_frame(input logic [15:0] a, input logic [15:0] d);
        logic [31:0] w;
        w = {d, a};
        push_run(1'b1, LM);
        push_run(1'b0, LS);
        for (int i = 0; i < 32; i++) begin
            push_run(1'b1, BM);
            push_run(1'b0, w[i] ? OS : ZS);
        end
        push_run(1'b1, BM);
        push_run(1'b0, GAP);
    endtask

    task automatic compare_wave(input string name);
        int bad;
        int first;
        bad = 0;
        first = -1;
        check({name, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        check({name, "_wave_diffs"}, bad, 0);
        if (bad != 0) $display("  first waveform difference at sample %0d", first);
    endtask

    task automatic get_runs();
        int cnt;
        runs.delete();
        if (got_q.size() == 0) return;
        cnt = 1;
        for (int i = 1; i < got_q.size(); i++) begin
            if (got_q[i] == got_q[i-1]) begin
                cnt++;
            end else begin
                runs.push_back(cnt);
                cnt = 1;
            end
        end
        runs.push_back(cnt);
    endtask

    // Leaves the bench at the negedge of the first cycle after the accept edge.
    task automatic send(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        bus.tx_addr = a;
        bus.tx_data = d;
        bus.start   = 1'b1;
        @(negedge clk);
    endtask

    // Records oIR per cycle until done; start is pulsed at sample indices pa/pb.
    task automatic capture(input int pa, input int pb);
        bit bp;
        bit ok;
        got_q.delete();
        cap_busy  = 0;
        cap_done  = 0;
        cap_falls = 0;
        bp = 1'b1;
        ok = 1'b0;
        for (int j = 0; j < LIMIT; j++) begin
            bus.start = (j == pa) || (j == pb);
            got_q.push_back(oir);
            if (bus.busy) cap_busy++;
            if (bp && !bus.busy) cap_falls++;
            bp = bus.busy;
            if (bus.done) begin
                cap_done++;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("frame_done_seen", int'(ok), 1);
    endtask

    task automatic run_vector(input int v, input int pa, input int pb);
        logic [31:0] dec;
        send(vecs[v].addr, vecs[v].data);
        capture(pa, pb);
        exp_q.delete();
        model_frame(vecs[v].addr, vecs[v].data);
        check("busy_cycles", cap_busy, vecs[v].busy);
        check("done_pulses", cap_done, 1);
        check("busy_falls", cap_falls, 1);
        compare_wave("frame");
`ifndef IR_CARRIER_EN
        get_runs();
        check("run_count", runs.size(), 68);
        if (runs.size() == 68) begin
            check("lead_mark", runs[0], LM);
            check("lead_space", runs[1], LS);
            check("bit0_space", runs[3], vecs[v].sp0);
            check("bit8_space", runs[19], vecs[v].sp8);
            check("stop_mark", runs[66], BM);
            check("gap_len", runs[67], GAP);
            for (int i = 0; i < 32; i++) dec[i] = (runs[3 + 2*i] == OS);
            check("decoded_frame", int'(dec), int'({vecs[v].data, vecs[v].addr}));
        end
`endif
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic post_idle(input int n);
        int b;
        int dn;
        b = 0;
        dn = 0;
        for (int i = 0; i < n; i++) begin
            if (bus.busy || oir) b++;
            if (bus.done) dn++;
            @(negedge clk);
        end
        check("no_extra_frame", b, 0);
        check("no_extra_done", dn, 0);
    endtask

    initial begin
        vecs[0] = '{16'h00FF, 16'h45BA, 336, 7, 3};
        vecs[1] = '{16'h1234, 16'hABCD, 332, 3, 3};
        vecs[2] = '{16'h0000, 16'h0000, 272, 3, 3};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 400, 7, 7};
        vecs[4] = '{16'hA5C3, 16'h0F0F, 336, 7, 7};

        bus.start   = 1'b0;
        bus.tx_addr = '0;
        bus.tx_data = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_done", int'(bus.done), 0);
        check("reset_oir", int'(oir), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 5; v++) run_vector(v, -1, -1);

        // start mid leader space and mid gap: ignored
        run_vector(1, LM + 5, 325);
        post_idle(40);
        // start in the done cycle: ignored
        run_vector(2, -1, 272);
        post_idle(40);

        // reset inside the bit 17 mark
        send(16'h1234, 16'hABCD);
        bus.start = 1'b0;
        repeat (175) @(negedge clk);
`ifndef IR_CARRIER_EN
        check("pre_reset_mark", int'(oir), 1);
`endif
        check("pre_reset_busy", int'(bus.busy), 1);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_oir", int'(oir), 0);
        check("async_reset_busy", int'(bus.busy), 0);
        check("async_reset_done", int'(bus.done), 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        run_vector(0, -1, -1);

        // start held: three back-to-back frames
        exp_q.delete();
        model_frame(16'hFFFF, 16'hFFFF);
        exp_q.push_back(1'b0);
        model_frame(16'h0000, 16'h0000);
        exp_q.push_back(1'b0);
        model_frame(16'hFFFF, 16'hFFFF);
        @(negedge clk);
        bus.tx_addr = 16'hFFFF;
        bus.tx_data = 16'hFFFF;
        bus.start   = 1'b1;
        @(negedge clk);
        got_q.delete();
        rises = 0;
        dones = 0;
        bprev = 1'b0;
        fin   = 1'b0;
        for (int j = 0; j < 3 * LIMIT; j++) begin
            got_q.push_back(oir);
            if (!bprev && bus.busy) begin
                rises++;
                if (rises == 1) begin
                    bus.tx_addr = 16'h0000;
                    bus.tx_data = 16'h0000;
                end else if (rises == 2) begin
                    bus.tx_addr = 16'hFFFF;
                    bus.tx_data = 16'hFFFF;
                end
            end
            bprev = bus.busy;
            if (bus.done) begin
                dones++;
                if (dones == 3) begin
                    fin = 1'b1;
                    bus.start = 1'b0;
                    break;
                end
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        check("b2b_finished", int'(fin), 1);
        check("b2b_frames", rises, 3);
        check("b2b_dones", dones, 3);
        compare_wave("b2b");
`ifndef IR_CARRIER_EN
        get_runs();
        check("b2b_run_count", runs.size(), 204);
        if (runs.size() == 204) begin
            check("b2b_gap1", runs[67], GAP + 1);
            check("b2b_gap2", runs[135], GAP + 1);
            check("b2b_last_gap", runs[203], GAP);
        end
`endif
        @(negedge clk);
        post_idle(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
